// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Button front end and control FSM for the stopwatch seconds
//               counter. Each button is synchronised, debounced and turned
//               into a single-cycle press event. The FSM drives the counter's
//               init_regs / count_enabled inputs and the split display hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl #(
    parameter int CLK_FREQ  = 100000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_split,
    output logic       init_regs,
    output logic       count_enabled,
    output logic       display_hold,
    output logic [1:0] state
);

    localparam int                 c_cnt_w   = $clog2(DB_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_db_last = c_cnt_w'(DB_CYCLES - 1);

    localparam logic [1:0] c_idle  = 2'b00;
    localparam logic [1:0] c_run   = 2'b01;
    localparam logic [1:0] c_pause = 2'b10;

    // Refuse to elaborate with a meaningless clock or debounce setting
    if (CLK_FREQ < 1 || DB_CYCLES < 1) begin : g_param_check
        $error("stopwatch_ctrl: CLK_FREQ and DB_CYCLES must be positive");
    end

    // Channel order: 0 = start, 1 = clear, 2 = split
    logic [2:0] w_raw;
    logic [2:0] w_press;

    assign w_raw = {btn_split, btn_clear, btn_start};

    for (genvar i = 0; i < 3; i++) begin : g_chan
        logic               r_sync1;
        logic               r_sync2;
        logic               r_level;
        logic               r_level_d;
        logic [c_cnt_w-1:0] r_cnt;

        // Synchronise, then flip the debounced level only after DB_CYCLES
        // consecutive cycles of disagreement with the synced input
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_level   <= 1'b0;
                r_level_d <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_sync1   <= w_raw[i];
                r_sync2   <= r_sync1;
                r_level_d <= r_level;
                if (r_sync2 == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_db_last) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        // Press event only on the debounced 0->1 edge; releases are silent
        assign w_press[i] = r_level & ~r_level_d;
    end

    logic       w_ev_start;
    logic       w_ev_clear;
    logic       w_ev_split;
    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_hold;
    logic       w_hold_next;
    logic       r_init;
    logic       w_init_next;
    logic       r_en;
    logic       w_en_next;

    assign w_ev_start = w_press[0];
    assign w_ev_clear = w_press[1];
    assign w_ev_split = w_press[2];

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
            r_hold  <= 1'b0;
            r_init  <= 1'b1;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_hold  <= w_hold_next;
            r_init  <= w_init_next;
            r_en    <= w_en_next;
        end
    end

    // Next-state logic; clear beats start beats split
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold;
        case (r_state)
            c_idle: begin
                w_hold_next = 1'b0;
                if (w_ev_start) begin
                    w_state_next = c_run;
                end
            end
            c_run: begin
                if (w_ev_clear) begin
                    w_state_next = c_idle;
                    w_hold_next  = 1'b0;
                end else if (w_ev_start) begin
                    w_state_next = c_pause;
                end else if (w_ev_split) begin
                    w_hold_next = ~r_hold;
                end
            end
            c_pause: begin
                if (w_ev_clear) begin
                    w_state_next = c_idle;
                    w_hold_next  = 1'b0;
                end else if (w_ev_start) begin
                    w_state_next = c_run;
                end else if (w_ev_split) begin
                    w_hold_next = 1'b0;
                end
            end
            default: begin
                w_state_next = c_idle;
                w_hold_next  = 1'b0;
            end
        endcase
    end

    // Counter controls decoded from the next state so they register with it
    always_comb begin
        w_init_next = (w_state_next == c_idle);
        w_en_next   = (w_state_next == c_run);
    end

    assign state         = r_state;
    assign display_hold  = r_hold;
    assign init_regs     = r_init;
    assign count_enabled = r_en;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Self-checking bench for stopwatch_ctrl (DB_CYCLES = 4).
//               Directed table, corner sequences and a randomized run checked
//               against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_split = 1'b0;
    logic       init_regs;
    logic       count_enabled;
    logic       display_hold;
    logic [1:0] state;

    int n_cmp = 0;
    int n_err = 0;

    stopwatch_ctrl #(
        .CLK_FREQ  (100000000),
        .DB_CYCLES (DB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_start     (btn_start),
        .btn_clear     (btn_clear),
        .btn_split     (btn_split),
        .init_regs     (init_regs),
        .count_enabled (count_enabled),
        .display_hold  (display_hold),
        .state         (state)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // m_st: 0 idle, 1 run, 2 pause. Index 0 start, 1 clear, 2 split.
    int m_run[3];
    bit m_s1[3], m_s2[3], m_lvl[3], m_lvld[3];
    int m_st;
    bit m_hold;

    always @(posedge clk or posedge reset) begin : model
        bit ev[3];
        bit raw[3];
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_run[i] = 0; m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_lvld[i] = 0;
            end
            m_st   = 0;
            m_hold = 0;
        end else begin
            raw = '{btn_start, btn_clear, btn_split};
            for (int i = 0; i < 3; i++) ev[i] = m_lvl[i] && !m_lvld[i];
            if (m_st == 0) begin
                m_hold = 0;
                if (ev[0]) m_st = 1;
            end else if (m_st == 1) begin
                if (ev[1]) begin m_st = 0; m_hold = 0; end
                else if (ev[0]) m_st = 2;
                else if (ev[2]) m_hold = !m_hold;
            end else begin
                if (ev[1]) begin m_st = 0; m_hold = 0; end
                else if (ev[0]) m_st = 1;
                else if (ev[2]) m_hold = 0;
            end
            for (int i = 0; i < 3; i++) begin
                m_lvld[i] = m_lvl[i];
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_lvl[i] = !m_lvl[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
        end
    end

    // Packed view {state, init_regs, count_enabled, display_hold}
    function automatic logic [4:0] dut_out();
        return {state, init_regs, count_enabled, display_hold};
    endfunction

    function automatic logic [4:0] model_out();
        return {2'(m_st), (m_st == 0), (m_st == 1), m_hold};
    endfunction

    task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b required %b", nm, $time, act, exp);
        end
    endtask

    // One clock, sampled 3 time units after the rising edge, model-checked
    task automatic tick();
        @(posedge clk);
        #3;
        check("model", dut_out(), model_out());
    endtask

    task automatic press(input bit s, input bit c, input bit p, input int hold);
        btn_start = s; btn_clear = c; btn_split = p;
        repeat (hold) tick();
        btn_start = 0; btn_clear = 0; btn_split = 0;
        repeat (8) tick();
    endtask

    typedef struct {
        bit         s;
        bit         c;
        bit         p;
        logic [4:0] exp;
    } vec_t;

    vec_t vt[17];

    initial begin
        // {state, init, en, hold}
        vt[0]  = '{0, 0, 1, 5'b00_1_0_0};  // split ignored in idle
        vt[1]  = '{0, 1, 0, 5'b00_1_0_0};  // clear ignored in idle
        vt[2]  = '{1, 0, 0, 5'b01_0_1_0};  // start -> run
        vt[3]  = '{0, 0, 1, 5'b01_0_1_1};  // split -> hold
        vt[4]  = '{0, 0, 1, 5'b01_0_1_0};  // split -> release hold
        vt[5]  = '{0, 0, 1, 5'b01_0_1_1};
        vt[6]  = '{1, 0, 0, 5'b10_0_0_1};  // pause keeps hold
        vt[7]  = '{0, 0, 1, 5'b10_0_0_0};  // split in pause clears hold
        vt[8]  = '{1, 0, 0, 5'b01_0_1_0};
        vt[9]  = '{0, 0, 1, 5'b01_0_1_1};
        vt[10] = '{1, 0, 1, 5'b10_0_0_1};  // start+split: pause, hold unchanged
        vt[11] = '{1, 0, 0, 5'b01_0_1_1};
        vt[12] = '{1, 1, 0, 5'b00_1_0_0};  // clear+start: idle
        vt[13] = '{1, 0, 0, 5'b01_0_1_0};
        vt[14] = '{0, 0, 1, 5'b01_0_1_1};
        vt[15] = '{0, 1, 0, 5'b00_1_0_0};  // split then clear: hold dropped
        vt[16] = '{0, 1, 1, 5'b00_1_0_0};

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        check("reset_state", dut_out(), 5'b00_1_0_0);
        reset = 0;

        // Idle with no buttons
        repeat (50) begin
            tick();
            check("idle_quiet", dut_out(), 5'b00_1_0_0);
        end

        // Bouncy start: 1x3, 0x2, then rise and hold
        btn_start = 1; repeat (3) tick();
        btn_start = 0; repeat (2) tick();
        btn_start = 1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) check("latency_before", {4'b0, count_enabled}, 5'b0);
            if (k == 7) check("latency_at", {4'b0, count_enabled}, 5'b1);
        end
        repeat (20) tick();
        check("single_event_hold", dut_out(), 5'b01_0_1_0);
        btn_start = 0;
        repeat (8) tick();
        press(0, 1, 0, 8);
        check("clear_to_idle", dut_out(), 5'b00_1_0_0);

        // Directed table
        for (int i = 0; i < 17; i++) begin
            press(vt[i].s, vt[i].c, vt[i].p, 8);
            check($sformatf("table_%0d", i), dut_out(), vt[i].exp);
        end

        // Start and clear together in run, held exactly DB+2 cycles
        press(1, 0, 0, 8);
        check("run_before_sim", dut_out(), 5'b01_0_1_0);
        btn_start = 1; btn_clear = 1;
        for (int k = 0; k < 14; k++) begin
            if (k == 6) begin btn_start = 0; btn_clear = 0; end
            tick();
            check("no_pause", {3'b0, state}, (state == 2'b10) ? 5'b0_0111 : {3'b0, state});
        end
        check("sim_clear_wins", dut_out(), 5'b00_1_0_0);

        // Asynchronous reset in run with split mid-debounce, held through release
        press(1, 0, 0, 8);
        check("run_before_reset", dut_out(), 5'b01_0_1_0);
        btn_split = 1;
        repeat (3) tick();
        reset = 1;
        #1;
        check("async_reset", dut_out(), 5'b00_1_0_0);
        tick();
        reset = 0;
        repeat (12) tick();
        check("split_after_reset_ignored", dut_out(), 5'b00_1_0_0);
        btn_split = 0;
        repeat (8) tick();

        // Randomized buttons and occasional resets against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 23) == 0) btn_clear = ~btn_clear;
            if ($urandom_range(0, 11) == 0) btn_split = ~btn_split;
            if ($urandom_range(0, 699) == 0) begin
                reset = 1;
                #1;
                check("rand_reset", dut_out(), 5'b00_1_0_0);
                tick();
                reset = 0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
